// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core front end.
//   fetch_state_t : fetch FSM encoding (REQ, WAIT, HOLD, DROP)
//   NOP_INS       : bubble instruction presented when nothing is valid
//   INS_BYTES     : instruction size in bytes, the PC increment
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // issuing a request for pc
    WAIT = 2'd1,  // request outstanding, waiting for the response
    HOLD = 2'd2,  // instruction captured in buf while IF/ID is stalled
    DROP = 2'd3   // stale response outstanding after a redirect
  } fetch_state_t;

  localparam logic [31:0] NOP_INS   = 32'b0;
  localparam logic [31:0] INS_BYTES = 32'd4;

endpackage : core_pkg

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, keeps at
// most one instruction-memory request outstanding, and presents one fetched
// instruction with its return address (PC+4). Presents an all-zero bubble
// whenever no valid instruction is ready.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   stall        IF/ID hold; the presented instruction is not consumed
//   redirect     taken branch/jump; overrides everything in the cycle
//   redirect_pc  new fetch address; bits [1:0] ignored
//   imem_req     request strobe, one cycle per request
//   imem_addr    request address (the PC)
//   imem_ready   one-cycle response strobe
//   imem_rdata   instruction word, valid with imem_ready
//   IF_ra        PC+4 of the presented instruction, 0 on a bubble
//   IF_ins       presented instruction, NOP_INS on a bubble
// ---------------------------------------------------------------------------
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ra,
  output logic [31:0] IF_ins
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  buf_q;
  logic [31:0]  pc_inc;
  logic [31:0]  redirect_word;

  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0 silently.
  assign pc_inc        = pc_q + INS_BYTES;
  assign redirect_word = {redirect_pc[31:2], 2'b00};

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;

  // NOTE: every register below uses <= so all of them see the pre-edge
  // values of each other; blocking assignments here would create ordering
  // dependent behaviour between pc_q, buf_q and state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INS;
    end else if (redirect) begin
      pc_q <= redirect_word;
      unique case (state_q)
        // The request issued this cycle is still in flight.
        REQ:        state_q <= DROP;
        // With no response yet, the old one must be drained before a new
        // request; if it arrives now it is simply discarded.
        WAIT, DROP: state_q <= imem_ready ? REQ : DROP;
        HOLD:       state_q <= REQ;
        default:    state_q <= REQ;
      endcase
    end else begin
      unique case (state_q)
        // A response here would be a protocol violation; it is ignored.
        REQ: state_q <= WAIT;
        WAIT: begin
          if (imem_ready) begin
            if (stall) begin
              buf_q   <= imem_rdata;
              state_q <= HOLD;
            end else begin
              pc_q    <= pc_inc;
              state_q <= REQ;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_q    <= pc_inc;
            state_q <= REQ;
          end
        end
        DROP: begin
          if (imem_ready) state_q <= REQ;
        end
        default: state_q <= REQ;
      endcase
    end
  end

  // NOTE: outputs get a default before any conditional assignment so the
  // block is purely combinational and no latch is inferred.
  always_comb begin
    IF_ins = NOP_INS;
    IF_ra  = 32'b0;
    if (!redirect) begin
      if (state_q == WAIT && imem_ready) begin
        IF_ins = imem_rdata;
        IF_ra  = pc_inc;
      end else if (state_q == HOLD) begin
        IF_ins = buf_q;
        IF_ra  = pc_inc;
      end
    end
  end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with a single-outstanding memory model of
// programmable latency. Inputs change 2 time units after the rising edge;
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ra;
  logic [31:0] IF_ins;

  int tests_run = 0;
  int tests_failed = 0;

  // Memory model controls
  int          lat = 1;
  int          cnt = 0;
  logic        req_s;
  logic [31:0] addr_s;
  logic [31:0] paddr;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .IF_ra      (IF_ra),
    .IF_ins     (IF_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: a request seen at a rising edge answers L cycles later, for one
  // cycle. Default data is 32'h1000_0000 | address, or ovr_data if enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        = 0;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
    end else begin
      req_s  = imem_req;
      addr_s = imem_addr;
      if (req_s) begin
        cnt   = lat;
        paddr = addr_s;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
      end
      #1;
      imem_ready = (cnt == 1);
      imem_rdata = (cnt == 1) ? (ovr_en ? ovr_data : (32'h1000_0000 | paddr)) : 32'h0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'h0;

    // Outputs while held in reset
    repeat (2) @(posedge clk);
    #2;
    check("rst_req", {31'b0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ins", IF_ins, 32'h0);
    check("rst_ra", IF_ra, 32'h0);

    // Free run, L=1, no stall
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("run_addr0", imem_addr, 32'h0);
    check("run_req0", {31'b0, imem_req}, 32'd1);
    tick(); sample();
    check("run_ins0", IF_ins, 32'h1000_0000);
    check("run_ra0", IF_ra, 32'd4);
    check("run_wait_req", {31'b0, imem_req}, 32'd0);
    tick(); sample();
    check("run_addr1", imem_addr, 32'd4);
    check("run_bubble", IF_ins, 32'h0);
    tick(); sample();
    check("run_ins1", IF_ins, 32'h1000_0004);
    check("run_ra1", IF_ra, 32'd8);
    tick(); sample();
    check("run_addr2", imem_addr, 32'd8);
    tick(); sample();
    check("run_ins2", IF_ins, 32'h1000_0008);
    check("run_ra2", IF_ra, 32'd12);

    // Stall on presentation for 3 cycles
    ovr_en   = 1'b1;
    ovr_data = 32'h2002_0005;
    tick(); stall = 1'b1; sample();
    check("stl_addr", imem_addr, 32'd12);
    tick(); sample();
    check("stl_ins_a", IF_ins, 32'h2002_0005);
    check("stl_ra_a", IF_ra, 32'd16);
    tick(); sample();
    check("stl_ins_b", IF_ins, 32'h2002_0005);
    check("stl_req_b", {31'b0, imem_req}, 32'd0);
    tick(); sample();
    check("stl_ins_c", IF_ins, 32'h2002_0005);
    check("stl_req_c", {31'b0, imem_req}, 32'd0);
    tick(); stall = 1'b0; sample();
    check("stl_ins_rel", IF_ins, 32'h2002_0005);
    check("stl_req_rel", {31'b0, imem_req}, 32'd0);
    tick(); ovr_en = 1'b0; sample();
    check("stl_next_req", {31'b0, imem_req}, 32'd1);
    check("stl_next_addr", imem_addr, 32'd16);

    // Redirect during WAIT, L=3
    lat = 3;
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103; sample();
    check("rdw_ins", IF_ins, 32'h0);
    check("rdw_req", {31'b0, imem_req}, 32'd0);
    tick(); redirect = 1'b0; sample();
    check("rdw_drop_req", {31'b0, imem_req}, 32'd0);
    tick(); sample();
    check("rdw_stale_rdy", {31'b0, imem_ready}, 32'd1);
    check("rdw_stale_ins", IF_ins, 32'h0);
    check("rdw_stale_ra", IF_ra, 32'h0);
    tick(); lat = 1; sample();
    check("rdw_new_req", {31'b0, imem_req}, 32'd1);
    check("rdw_new_addr", imem_addr, 32'h0000_0100);

    // Redirect coincident with imem_ready while stalled
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0200; stall = 1'b1; sample();
    check("rdr_rdy", {31'b0, imem_ready}, 32'd1);
    check("rdr_ins", IF_ins, 32'h0);
    check("rdr_ra", IF_ra, 32'h0);
    tick(); redirect = 1'b0; stall = 1'b0; sample();
    check("rdr_req", {31'b0, imem_req}, 32'd1);
    check("rdr_addr", imem_addr, 32'h0000_0200);

    // Async reset while in HOLD
    tick(); stall = 1'b1; sample();
    check("hrs_ins_w", IF_ins, 32'h1000_0200);
    check("hrs_ra_w", IF_ra, 32'h0000_0204);
    tick(); sample();
    check("hrs_ins_h", IF_ins, 32'h1000_0200);
    #2;
    rst_n = 1'b0;
    #1;
    check("hrs_rst_ins", IF_ins, 32'h0);
    check("hrs_rst_ra", IF_ra, 32'h0);
    check("hrs_rst_addr", imem_addr, 32'h0);
    check("hrs_buf", dut.buf_q, 32'h0);
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    check("hrs_rel_req", {31'b0, imem_req}, 32'd1);
    check("hrs_rel_addr", imem_addr, 32'h0);
    tick(); sample();
    check("hrs_first_ins", IF_ins, 32'h1000_0000);
    check("hrs_first_ra", IF_ra, 32'd4);

    // PC wrap: redirect to the top word while in REQ, then consume
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; sample();
    check("wrp_req_addr", imem_addr, 32'd4);
    tick(); redirect = 1'b0; sample();
    check("wrp_drop_ins", IF_ins, 32'h0);
    tick(); sample();
    check("wrp_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); sample();
    check("wrp_ins", IF_ins, 32'hFFFF_FFFC);
    check("wrp_ra", IF_ra, 32'h0);
    tick(); sample();
    check("wrp_next_addr", imem_addr, 32'h0);
    check("wrp_next_req", {31'b0, imem_req}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fetch_unit
